// File: rtl/axilite_cfg_pkg.sv
// Shared types and constants for the AXI-Lite configuration writer:
// FSM state encoding, BRESP codes and the error classification helper.
package axilite_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both carry bit 1 set; OKAY/EXOKAY do not.
  function automatic logic is_error(input logic [1:0] bresp);
    return bresp[1];
  endfunction

endpackage

// File: rtl/axilite_config_writer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of the order of always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axilite_config_writer.sv
// Turns {addr, data} stream commands into single AXI-Lite writes, one
// outstanding at a time, and tracks completed-write and error counts.
module axilite_config_writer
  import axilite_cfg_pkg::*;
#(
  parameter int m_axilite_cfg_WIDTH      = 32,
  parameter int m_axilite_cfg_ADDR_WIDTH = 12,
  parameter int ERR_COUNT_WIDTH          = 16
) (
  input  logic                                                ap_clk,
  input  logic                                                ap_rst_n,
  input  logic [m_axilite_cfg_ADDR_WIDTH+m_axilite_cfg_WIDTH-1:0] s_axis_cmd_tdata,
  input  logic                                                s_axis_cmd_tvalid,
  output logic                                                s_axis_cmd_tready,
  output logic                                                m_axilite_cfg_awvalid,
  input  logic                                                m_axilite_cfg_awready,
  output logic [m_axilite_cfg_ADDR_WIDTH-1:0]                 m_axilite_cfg_awaddr,
  output logic                                                m_axilite_cfg_wvalid,
  input  logic                                                m_axilite_cfg_wready,
  output logic [m_axilite_cfg_WIDTH-1:0]                      m_axilite_cfg_wdata,
  output logic [m_axilite_cfg_WIDTH/8-1:0]                    m_axilite_cfg_wstrb,
  input  logic                                                m_axilite_cfg_bvalid,
  output logic                                                m_axilite_cfg_bready,
  input  logic [1:0]                                          m_axilite_cfg_bresp,
  input  logic                                                clr_counts,
  output logic                                                busy,
  output logic [31:0]                                         wr_count,
  output logic [ERR_COUNT_WIDTH-1:0]                          err_count,
  output logic [1:0]                                          last_bresp
);

  localparam int W = m_axilite_cfg_WIDTH;
  localparam int A = m_axilite_cfg_ADDR_WIDTH;

  state_e state, state_next;
  logic   init_done;
  logic   cmd_fire, aw_fire, w_fire, b_fire;

  assign cmd_fire = s_axis_cmd_tvalid && s_axis_cmd_tready;
  assign aw_fire  = m_axilite_cfg_awvalid && m_axilite_cfg_awready;
  assign w_fire   = m_axilite_cfg_wvalid && m_axilite_cfg_wready;
  assign b_fire   = (state == ST_RESP) && m_axilite_cfg_bvalid;

  // State register. init_done holds tready low until the first edge after reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ST_IDLE;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= 1'b1;
    end
  end

  // NOTE: the first assignment is a default for every path, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (cmd_fire) state_next = ST_WRITE;
      ST_WRITE: if ((!m_axilite_cfg_awvalid || m_axilite_cfg_awready) &&
                    (!m_axilite_cfg_wvalid  || m_axilite_cfg_wready))
                  state_next = ST_RESP;
      ST_RESP:  if (m_axilite_cfg_bvalid) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_cmd_tready    = (state == ST_IDLE) && init_done;
    busy                 = (state != ST_IDLE);
    m_axilite_cfg_bready = (state == ST_RESP);
    m_axilite_cfg_wstrb  = m_axilite_cfg_wvalid ? '1 : '0;
  end

  // Valids are plain registers so they never follow ready combinationally;
  // each channel retires on its own handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_axilite_cfg_awvalid <= 1'b0;
      m_axilite_cfg_wvalid  <= 1'b0;
      m_axilite_cfg_awaddr  <= '0;
      m_axilite_cfg_wdata   <= '0;
    end else if (cmd_fire) begin
      m_axilite_cfg_awvalid <= 1'b1;
      m_axilite_cfg_wvalid  <= 1'b1;
      m_axilite_cfg_awaddr  <= s_axis_cmd_tdata[A+W-1:W];
      m_axilite_cfg_wdata   <= s_axis_cmd_tdata[W-1:0];
    end else begin
      if (aw_fire) m_axilite_cfg_awvalid <= 1'b0;
      if (w_fire)  m_axilite_cfg_wvalid  <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_count   <= '0;
      last_bresp <= RESP_OKAY;
    end else begin
      if (clr_counts)  wr_count <= '0;
      else if (b_fire) wr_count <= wr_count + 32'd1;
      if (b_fire) last_bresp <= m_axilite_cfg_bresp;
    end
  end

  sat_counter #(
    .WIDTH(ERR_COUNT_WIDTH)
  ) u_err_counter (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .inc   (b_fire && is_error(m_axilite_cfg_bresp)),
    .clr   (clr_counts),
    .count (err_count)
  );

endmodule

// File: tb/tb_axilite_config_writer.sv
// Directed bench for axilite_config_writer: a default-width DUT and a
// 2-bit error-counter DUT share all stimulus; a queue holds expected writes.
module tb_axilite_config_writer;
  import axilite_cfg_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic           ap_clk   = 1'b0;
  logic           ap_rst_n = 1'b0;
  logic [AW+DW-1:0] tdata  = '0;
  logic           tvalid   = 1'b0;
  logic           awready  = 1'b0;
  logic           wready   = 1'b0;
  logic           bvalid   = 1'b0;
  logic [1:0]     bresp    = 2'b00;
  logic           clr      = 1'b0;

  logic           tready, awvalid, wvalid, bready, busy;
  logic [AW-1:0]  awaddr;
  logic [DW-1:0]  wdata;
  logic [SW-1:0]  wstrb;
  logic [31:0]    wr_count;
  logic [15:0]    err_count;
  logic [1:0]     last_bresp;

  logic           s_tready, s_awvalid, s_wvalid, s_bready, s_busy;
  logic [AW-1:0]  s_awaddr;
  logic [DW-1:0]  s_wdata;
  logic [SW-1:0]  s_wstrb;
  logic [31:0]    s_wr_count;
  logic [1:0]     s_err_count;
  logic [1:0]     s_last_bresp;

  always #5 ap_clk = ~ap_clk;

  axilite_config_writer #(
    .m_axilite_cfg_WIDTH(DW), .m_axilite_cfg_ADDR_WIDTH(AW), .ERR_COUNT_WIDTH(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_cmd_tdata(tdata), .s_axis_cmd_tvalid(tvalid), .s_axis_cmd_tready(tready),
    .m_axilite_cfg_awvalid(awvalid), .m_axilite_cfg_awready(awready), .m_axilite_cfg_awaddr(awaddr),
    .m_axilite_cfg_wvalid(wvalid), .m_axilite_cfg_wready(wready), .m_axilite_cfg_wdata(wdata),
    .m_axilite_cfg_wstrb(wstrb), .m_axilite_cfg_bvalid(bvalid), .m_axilite_cfg_bready(bready),
    .m_axilite_cfg_bresp(bresp), .clr_counts(clr), .busy(busy), .wr_count(wr_count),
    .err_count(err_count), .last_bresp(last_bresp)
  );

  axilite_config_writer #(
    .m_axilite_cfg_WIDTH(DW), .m_axilite_cfg_ADDR_WIDTH(AW), .ERR_COUNT_WIDTH(2)
  ) dut_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_cmd_tdata(tdata), .s_axis_cmd_tvalid(tvalid), .s_axis_cmd_tready(s_tready),
    .m_axilite_cfg_awvalid(s_awvalid), .m_axilite_cfg_awready(awready), .m_axilite_cfg_awaddr(s_awaddr),
    .m_axilite_cfg_wvalid(s_wvalid), .m_axilite_cfg_wready(wready), .m_axilite_cfg_wdata(s_wdata),
    .m_axilite_cfg_wstrb(s_wstrb), .m_axilite_cfg_bvalid(bvalid), .m_axilite_cfg_bready(s_bready),
    .m_axilite_cfg_bresp(bresp), .clr_counts(clr), .busy(s_busy), .wr_count(s_wr_count),
    .err_count(s_err_count), .last_bresp(s_last_bresp)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } txn_t;

  txn_t sb[$];
  int   n_tests     = 0;
  int   n_fail      = 0;
  int   exp_wr      = 0;
  int   exp_err     = 0;
  int   exp_err_sat = 0;
  logic [SW-1:0] all_strb = '1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_wr_count"},  64'(wr_count),    64'(exp_wr));
    check_val({tag, "_err_count"}, 64'(err_count),   64'(exp_err));
    check_val({tag, "_err_sat"},   64'(s_err_count), 64'(exp_err_sat));
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_wr = 0; exp_err = 0; exp_err_sat = 0;
    check_counts("clear");
  endtask

  // One complete write; bvalid is driven high with a bogus code during WRITE
  // to confirm the DUT ignores it until it is in the response phase.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [1:0] resp, input int aw_lat, input int w_lat,
                          input bit clr_at_b);
    txn_t t;
    int   k;
    bit   aw_hs, w_hs, done;
    k = 0;
    while (!tready && k < 20) begin tick(); k++; end
    check_val("cmd_tready", 64'(tready), 64'd1);
    t.addr = addr; t.data = data; t.resp = resp;
    sb.push_back(t);
    tdata = {addr, data}; tvalid = 1'b1;
    tick();
    tvalid = 1'b0; tdata = '0;
    check_val("awvalid_cycle1", 64'(awvalid), 64'd1);
    check_val("wvalid_cycle1",  64'(wvalid),  64'd1);
    check_val("tready_busy",    64'(tready),  64'd0);
    aw_hs = 1'b0; w_hs = 1'b0; done = 1'b0; k = 0;
    while (!done) begin
      if (aw_hs) check_val("aw_drop", 64'(awvalid), 64'd0);
      if (w_hs)  check_val("w_drop",  64'(wvalid),  64'd0);
      if (!awvalid && !wvalid) begin
        done = 1'b1;
      end else if (k >= 50) begin
        check_val("write_timeout", 64'({awvalid, wvalid}), 64'd0);
        done = 1'b1;
      end else begin
        if (awvalid) check_val("awaddr", 64'(awaddr), 64'(sb[0].addr));
        if (wvalid) begin
          check_val("wdata", 64'(wdata), 64'(sb[0].data));
          check_val("wstrb", 64'(wstrb), 64'(all_strb));
        end else begin
          check_val("wstrb_idle", 64'(wstrb), 64'd0);
        end
        check_val("bready_write", 64'(bready), 64'd0);
        bvalid  = 1'b1; bresp = RESP_DECERR;
        awready = (k >= aw_lat);
        wready  = (k >= w_lat);
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        tick();
        k++;
      end
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = RESP_OKAY;
    if (aw_lat == 0 && w_lat == 0) check_val("min_latency", 64'(k), 64'd1);
    check_val("bready_resp", 64'(bready), 64'd1);
    check_val("busy_resp",   64'(busy),   64'd1);
    check_counts("hold_in_resp");
    t = sb.pop_front();
    bvalid = 1'b1; bresp = t.resp; clr = clr_at_b;
    if (clr_at_b) begin
      exp_wr = 0; exp_err = 0; exp_err_sat = 0;
    end else begin
      exp_wr++;
      if (is_error(t.resp)) begin
        if (exp_err < 65535) exp_err++;
        if (exp_err_sat < 3) exp_err_sat++;
      end
    end
    tick();
    bvalid = 1'b0; bresp = RESP_OKAY; clr = 1'b0;
    check_val("last_bresp", 64'(last_bresp), 64'(t.resp));
    check_val("idle_tready", 64'(tready),    64'd1);
    check_val("idle_busy",   64'(busy),      64'd0);
    check_val("idle_bready", 64'(bready),    64'd0);
    check_counts("after_b");
  endtask

  initial begin
    #3;
    check_val("rst_outputs", 64'({tready, awvalid, wvalid, bready, busy, wstrb}), 64'd0);
    check_val("rst_regs", 64'({awaddr, last_bresp}), 64'd0);
    check_val("rst_wdata", 64'(wdata), 64'd0);
    check_counts("rst");
    #19 ap_rst_n = 1'b1;
    #1 check_val("tready_before_edge", 64'(tready), 64'd0);
    tick();
    check_val("tready_first_edge", 64'(tready), 64'd1);

    do_write(12'h010, 32'hDEADBEEF, RESP_OKAY, 0, 0, 1'b0);
    check_val("first_wr_count", 64'(wr_count), 64'd1);
    do_write(12'h024, 32'h12345678, RESP_OKAY, 4, 0, 1'b0);
    do_write(12'h7FC, 32'hA5A5_5A5A, RESP_EXOKAY, 0, 3, 1'b0);

    clear_counts();
    do_write(12'h100, 32'h0000_0001, RESP_SLVERR, 0, 0, 1'b0);
    do_write(12'h104, 32'h0000_0002, RESP_DECERR, 1, 1, 1'b0);
    do_write(12'h108, 32'h0000_0003, RESP_OKAY,   2, 0, 1'b0);
    check_val("three_err", 64'(err_count), 64'd2);
    check_val("three_wr",  64'(wr_count),  64'd3);
    check_val("three_last", 64'(last_bresp), 64'(RESP_OKAY));

    for (int i = 0; i < 5; i++)
      do_write(12'h200 + 12'(i * 4), 32'hC0DE_0000 + 32'(i), RESP_SLVERR, 0, 0, 1'b0);
    check_val("sat_err", 64'(s_err_count), 64'd3);
    check_val("wide_err", 64'(err_count), 64'd7);

    do_write(12'h300, 32'hFEED_F00D, RESP_SLVERR, 0, 0, 1'b1);
    check_val("clr_wins_wr",  64'(wr_count),   64'd0);
    check_val("clr_wins_err", 64'(err_count),  64'd0);
    check_val("clr_last",     64'(last_bresp), 64'(RESP_SLVERR));

    do_write(12'h040, 32'h1111_2222, RESP_OKAY, 0, 0, 1'b0);
    tdata = {12'h044, 32'h3333_4444}; tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    check_val("midrst_pre_aw", 64'({awvalid, wvalid}), 64'b11);
    #2 ap_rst_n = 1'b0;
    #1;
    check_val("midrst_valids", 64'({awvalid, wvalid, s_awvalid, s_wvalid}), 64'd0);
    check_val("midrst_ctrl", 64'({tready, bready, busy, wstrb}), 64'd0);
    check_val("midrst_addr", 64'({awaddr, last_bresp}), 64'd0);
    exp_wr = 0; exp_err = 0; exp_err_sat = 0;
    sb.delete();
    check_counts("midrst");
    bvalid = 1'b1; bresp = RESP_SLVERR;
    @(negedge ap_clk);
    bvalid = 1'b0; bresp = RESP_OKAY;
    ap_rst_n = 1'b1;
    tick();
    check_val("midrst_tready", 64'(tready), 64'd1);
    check_counts("post_rst");
    do_write(12'h048, 32'h5555_6666, RESP_OKAY, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axilite_config_writer.md
AXILITE_CONFIG_WRITER -- requirements
Module: axilite_config_writer

Interface
REQ-001 SHALL have parameter m_axilite_cfg_WIDTH, default 32: AXI-Lite write-data width in bits (32 or 64).
REQ-002 SHALL have parameter m_axilite_cfg_ADDR_WIDTH, default 12: AXI-Lite address width.
REQ-003 SHALL have parameter ERR_COUNT_WIDTH, default 16: width of the saturating error counter.
REQ-004 SHALL have one clock, with reset asynchronous and active-low.
REQ-005 ap_clk  in  1  sole clock; all logic rising-edge.
REQ-006 ap_rst_n  in  1  asynchronous active-low reset.
REQ-007 s_axis_cmd_tdata  in  ADDR_WIDTH+WIDTH  command word: {addr (upper bits), data (lower bits)}.
REQ-008 s_axis_cmd_tvalid  in  1 / s_axis_cmd_tready  out  1  command handshake.
REQ-009 m_axilite_cfg_awvalid  out  1 / m_axilite_cfg_awready  in  1 / m_axilite_cfg_awaddr  out  ADDR_WIDTH  write-address channel.
REQ-010 m_axilite_cfg_wvalid  out  1 / m_axilite_cfg_wready  in  1 / m_axilite_cfg_wdata  out  WIDTH / m_axilite_cfg_wstrb  out  WIDTH/8  write-data channel.
REQ-011 m_axilite_cfg_bvalid  in  1 / m_axilite_cfg_bready  out  1 / m_axilite_cfg_bresp  in  2  write-response channel.
REQ-012 clr_counts  in  1  synchronous clear of both counters.
REQ-013 busy  out  1 / wr_count  out  32 / err_count  out  ERR_COUNT_WIDTH / last_bresp  out  2  status outputs.

Function
REQ-014 FSM states SHALL be IDLE, WRITE and RESP; busy SHALL be high in every state except IDLE.
REQ-015 s_axis_cmd_tready SHALL be 1 only in IDLE, so at most one transaction is outstanding.
REQ-016 IDLE: on tvalid&&tready, SHALL latch addr/data, set awvalid=wvalid=1 on the next cycle, and go to WRITE.
REQ-017 awvalid SHALL drop the cycle after the awvalid&&awready handshake, and wvalid likewise after its own handshake; the two channels complete independently, in either order or in the same cycle.
REQ-018 awaddr/wdata SHALL stay stable while the corresponding valid is high; valids SHALL never depend combinationally on ready.
REQ-019 wstrb SHALL be all ones whenever wvalid is high, and 0 otherwise.
REQ-020 When both AW and W have completed, SHALL go to RESP with bready=1; bready SHALL be 0 in IDLE and WRITE, and bvalid in those states SHALL be ignored.
REQ-021 RESP: on bvalid, SHALL capture bresp into last_bresp, increment wr_count (wraps at 2^32), increment err_count if bresp[1]=1 (SLVERR/DECERR, saturating at all ones), and return to IDLE.
REQ-022 Minimum latency: cmd accepted at cycle 0, valids at cycle 1, RESP at cycle 2 if both readys are high at cycle 1, IDLE at cycle 3 if bvalid is high at cycle 2; peak rate is one write per 3 cycles.
REQ-023 clr_counts SHALL zero both counters on the next edge; if it coincides with an increment, clear SHALL win.
REQ-024 The block SHALL have no timeout: it waits indefinitely in WRITE/RESP.

Reset
REQ-025 While ap_rst_n=0, all outputs SHALL be 0 (awvalid, wvalid, bready, tready, busy, counters, last_bresp, awaddr, wdata, wstrb), and the state SHALL be IDLE.
REQ-026 Reset asserted mid-transaction SHALL drop the valids immediately (asynchronously) and abandon the transaction.
REQ-027 The first tready=1 SHALL occur on the first clock edge after reset deassertion.

Structure
REQ-028 Package axilite_cfg_pkg SHALL hold the FSM state enum, the BRESP constants (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and an is_error(bresp) function.
REQ-029 Sub-module sat_counter (parameterised width, inc, clr) SHALL implement err_count; wr_count SHALL stay inline.

Verification
REQ-030 Bench SHALL cover: cmd {0x010, 0xDEADBEEF}, all readys high, bresp=00 -> awaddr=0x010 and wdata=0xDEADBEEF at cycle 1, back in IDLE at cycle 3, wr_count=1, err_count=0.
REQ-031 Bench SHALL cover: awready delayed 4 cycles, wready immediate -> wvalid low after cycle 1, awvalid held with stable addr until handshake, bready rises only after both complete.
REQ-032 Bench SHALL cover: three writes answered 10, 11, 00 -> err_count=2, wr_count=3, last_bresp=00.
REQ-033 Bench SHALL cover: ERR_COUNT_WIDTH=2, five SLVERR responses -> err_count saturates at 3.
REQ-034 Bench SHALL cover: ap_rst_n pulsed low during WRITE -> valids drop immediately, no B handshake, counters 0, next command accepted normally.
REQ-035 Bench SHALL cover: clr_counts asserted in the same cycle as an erroring bvalid -> both counters 0 afterwards, last_bresp=10.
